alu_writeback_rf: RTL and testbench

//  Execute->writeback stage around the ALU. Registers the ALU result and NZCVD flags for one

---
 rtl/alu_writeback_rf.sv | 140 ++++++++++++++
 tb/tb_alu_writeback_rf.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback_rf.sv
// ============================================================================
// Module   : alu_writeback_rf
// Brief    : EX->WB pipeline register, 2**ADDR x DATA register file, status
//            flags and SDEPTH-deep flag stack. Optional macro RF_FORWARD_EN
//            enables WB->read forwarding (hazard then tied low).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_writeback_rf #(
  parameter int DATA   = 8,
  parameter int ADDR   = 3,
  parameter int FLAGS  = 5,
  parameter int SDEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [DATA-1:0]  ex_result,
  input  logic [FLAGS-1:0] ex_flags,
  input  logic [ADDR-1:0]  ex_dst,
  input  logic             ex_we,
  input  logic             ex_fe,
  input  logic [ADDR-1:0]  ra_addr,
  input  logic [ADDR-1:0]  rb_addr,
  output logic [DATA-1:0]  A,
  output logic [DATA-1:0]  B,
  output logic             hazard,
  output logic [FLAGS-1:0] flags,
  input  logic             flag_push,
  input  logic             flag_pop,
  output logic             stk_err
);

  localparam int                c_NREG    = 2**ADDR;
  localparam int                c_SPW     = $clog2(SDEPTH) + 1;
  localparam logic [c_SPW-1:0]  c_SP_FULL = c_SPW'(SDEPTH);

  logic             r_wb_valid;
  logic             r_wb_we;
  logic             r_wb_fe;
  logic [DATA-1:0]  r_wb_result;
  logic [FLAGS-1:0] r_wb_flags;
  logic [ADDR-1:0]  r_wb_dst;

  logic [DATA-1:0]  r_rf  [c_NREG];
  logic [FLAGS-1:0] r_stk [SDEPTH];
  logic [FLAGS-1:0] r_flags;
  logic [c_SPW-1:0] r_sp;
  logic             r_stk_err;

  logic             w_wb_wr;
  logic [c_SPW-1:0] w_sp_m1;
  logic [DATA-1:0]  w_a;
  logic [DATA-1:0]  w_b;

  assign w_wb_wr = r_wb_valid & r_wb_we & (r_wb_dst != '0);
  assign w_sp_m1 = r_sp - c_SPW'(1);

  always_comb begin
    w_a = r_rf[ra_addr];
    w_b = r_rf[rb_addr];
`ifdef RF_FORWARD_EN
    if (w_wb_wr && (r_wb_dst == ra_addr)) w_a = r_wb_result;
    if (w_wb_wr && (r_wb_dst == rb_addr)) w_b = r_wb_result;
`endif
    if (ra_addr == '0) w_a = '0;
    if (rb_addr == '0) w_b = '0;
  end

  assign A = w_a;
  assign B = w_b;

`ifdef RF_FORWARD_EN
  assign hazard = 1'b0;
`else
  assign hazard = w_wb_wr & ((r_wb_dst == ra_addr) | (r_wb_dst == rb_addr));
`endif

  assign flags   = r_flags;
  assign stk_err = r_stk_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_fe     <= 1'b0;
      r_wb_result <= '0;
      r_wb_flags  <= '0;
      r_wb_dst    <= '0;
    end else begin
      r_wb_valid <= ex_valid;
      if (ex_valid) begin
        r_wb_we     <= ex_we;
        r_wb_fe     <= ex_fe;
        r_wb_result <= ex_result;
        r_wb_flags  <= ex_flags;
        r_wb_dst    <= ex_dst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_NREG; i++) r_rf[i] <= '0;
    end else if (w_wb_wr) begin
      r_rf[r_wb_dst] <= r_wb_result;
    end
  end

  // Pop is ordered after the WB flag commit so a successful pop overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags   <= '0;
      r_sp      <= '0;
      r_stk_err <= 1'b0;
      for (int i = 0; i < SDEPTH; i++) r_stk[i] <= '0;
    end else begin
      if (r_wb_valid && r_wb_fe) r_flags <= r_wb_flags;
      if (flag_push && !flag_pop) begin
        if (r_sp != c_SP_FULL) begin
          r_stk[r_sp[c_SPW-2:0]] <= r_flags;
          r_sp                   <= r_sp + c_SPW'(1);
        end else begin
          r_stk_err <= 1'b1;
        end
      end else if (flag_pop && !flag_push) begin
        if (r_sp != '0) begin
          r_flags <= r_stk[w_sp_m1[c_SPW-2:0]];
          r_sp    <= w_sp_m1;
        end else begin
          r_stk_err <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_writeback_rf.sv
// ============================================================================
// Module   : tb_alu_writeback_rf
// Brief    : Directed vector table plus randomized run against a queue-based
//            reference model of alu_writeback_rf.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_writeback_rf;

`ifdef RF_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ex_valid = 1'b0, ex_we = 1'b0, ex_fe = 1'b0;
  logic [7:0] ex_result = '0;
  logic [4:0] ex_flags = '0;
  logic [2:0] ex_dst = '0, ra_addr = '0, rb_addr = '0;
  logic       flag_push = 1'b0, flag_pop = 1'b0;
  logic [7:0] A, B;
  logic       hazard, stk_err;
  logic [4:0] flags;

  int total = 0;
  int bad   = 0;

  alu_writeback_rf dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_flags(ex_flags), .ex_dst(ex_dst), .ex_we(ex_we), .ex_fe(ex_fe),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .A(A), .B(B), .hazard(hazard),
    .flags(flags), .flag_push(flag_push), .flag_pop(flag_pop), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       chk;
    logic       rst, v, we, fe;
    logic [2:0] dst;
    logic [7:0] res;
    logic [4:0] fl;
    logic [2:0] ra, rb;
    logic       push, pop;
    logic [7:0] ea, eb;
    logic       eh;
    logic [4:0] ef;
    logic       ee;
  } vec_t;

  // Reference model: architectural state plus one pending writeback record.
  logic [7:0] m_rf [8];
  logic [4:0] m_flags;
  logic [4:0] m_stk [$];
  logic       m_err, m_wbv, m_we, m_fe, m_init = 1'b0;
  logic [2:0] m_dst;
  logic [7:0] m_res;
  logic [4:0] m_fl;

  function automatic logic m_pending(input logic [2:0] a);
    return m_wbv && m_we && (m_dst != 3'd0) && (m_dst == a);
  endfunction

  function automatic logic [7:0] m_read(input logic [2:0] a);
    if (a == 3'd0) return 8'h00;
    if (FWD && m_pending(a)) return m_res;
    return m_rf[a];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [4:0] nf;
    if (rst) begin
      foreach (m_rf[i]) m_rf[i] = 8'h00;
      m_flags = '0; m_stk.delete(); m_err = 1'b0;
      m_wbv = 1'b0; m_we = 1'b0; m_fe = 1'b0; m_dst = '0; m_res = '0; m_fl = '0;
      m_init = 1'b1;
    end else if (m_init) begin
      nf = m_flags;
      if (m_wbv && m_we && m_dst != 3'd0) m_rf[m_dst] = m_res;
      if (m_wbv && m_fe) nf = m_fl;
      if (flag_push && !flag_pop) begin
        if (m_stk.size() < 4) m_stk.push_back(m_flags);
        else m_err = 1'b1;
      end else if (flag_pop && !flag_push) begin
        if (m_stk.size() > 0) nf = m_stk.pop_back();
        else m_err = 1'b1;
      end
      m_flags = nf;
      m_wbv = ex_valid; m_we = ex_we; m_fe = ex_fe;
      m_dst = ex_dst; m_res = ex_result; m_fl = ex_flags;
    end
  endtask

  task automatic step(input vec_t t);
    rst = t.rst; ex_valid = t.v; ex_we = t.we; ex_fe = t.fe; ex_dst = t.dst;
    ex_result = t.res; ex_flags = t.fl; ra_addr = t.ra; rb_addr = t.rb;
    flag_push = t.push; flag_pop = t.pop;
    #1;
    if (m_init) begin
      check("model_A", A, m_read(t.ra));
      check("model_B", B, m_read(t.rb));
      check("model_hazard", {7'd0, hazard},
            {7'd0, !FWD && (m_pending(t.ra) || m_pending(t.rb))});
      check("model_flags", {3'd0, flags}, {3'd0, m_flags});
      check("model_stk_err", {7'd0, stk_err}, {7'd0, m_err});
    end
    if (t.chk) begin
      check("tbl_A", A, t.ea);
      check("tbl_B", B, t.eb);
      check("tbl_hazard", {7'd0, hazard}, {7'd0, t.eh});
      check("tbl_flags", {3'd0, flags}, {3'd0, t.ef});
      check("tbl_stk_err", {7'd0, stk_err}, {7'd0, t.ee});
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // mk(chk, rst, v, we, fe, dst, res, fl, ra, rb, push, pop, eA, eB, eH, eF, eE)
  function automatic vec_t mk(input logic c, r, v, we, fe, input logic [2:0] d,
                              input logic [7:0] res, input logic [4:0] fl,
                              input logic [2:0] ra, rb, input logic pu, po,
                              input logic [7:0] ea, eb, input logic eh,
                              input logic [4:0] ef, input logic ee);
    vec_t t;
    t.chk = c; t.rst = r; t.v = v; t.we = we; t.fe = fe; t.dst = d; t.res = res;
    t.fl = fl; t.ra = ra; t.rb = rb; t.push = pu; t.pop = po;
    t.ea = ea; t.eb = eb; t.eh = eh; t.ef = ef; t.ee = ee;
    return t;
  endfunction

  vec_t tbl [$];

  initial begin
    // reset, then read every register
    tbl.push_back(mk(0,1,0,0,0,0,8'h00,5'h00,0,0,0,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,1,2,0,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,3,4,0,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,5,6,0,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,7,0,0,0, 8'h00,8'h00,0,5'h00,0));
    // R3 <= 5A, visible two edges later; R0 write discarded
    tbl.push_back(mk(1,0,1,1,0,3,8'h5A,5'h00,3,0,0,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,3,1,0,0, FWD ? 8'h5A : 8'h00,8'h00,!FWD,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,3,0,0,0, 8'h5A,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,1,1,0,0,8'hFF,5'h00,0,3,0,0, 8'h00,8'h5A,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,0,0,0,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,0,3,0,0, 8'h00,8'h5A,0,5'h00,0));
    // back-to-back read of R2 after write
    tbl.push_back(mk(1,0,1,1,0,2,8'h11,5'h00,1,1,0,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,0, FWD ? 8'h11 : 8'h00,8'h5A,!FWD,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h11,8'h5A,0,5'h00,0));
    // flag commit, push, commit, pop
    tbl.push_back(mk(1,0,1,0,1,0,8'h00,5'b01000,2,3,0,0, 8'h11,8'h5A,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h11,8'h5A,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,1,0, 8'h11,8'h5A,0,5'b01000,0));
    tbl.push_back(mk(1,0,1,0,1,0,8'h00,5'b10000,2,3,0,0, 8'h11,8'h5A,0,5'b01000,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h11,8'h5A,0,5'b01000,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,1, 8'h11,8'h5A,0,5'b10000,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h11,8'h5A,0,5'b01000,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,1, 8'h11,8'h5A,0,5'b01000,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h11,8'h5A,0,5'b01000,1));
    // overflow on 5th push, reset clears error, pop on empty
    tbl.push_back(mk(1,1,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h11,8'h5A,0,5'b01000,1));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,1,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,1,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,1,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,1,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,1,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h00,8'h00,0,5'h00,1));
    tbl.push_back(mk(1,1,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h00,8'h00,0,5'h00,1));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,1, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h00,8'h00,0,5'h00,1));
    // pop beats same-cycle commit; push+pop together is a no-op on sp
    tbl.push_back(mk(1,1,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h00,8'h00,0,5'h00,1));
    tbl.push_back(mk(1,0,1,0,1,0,8'h00,5'b00001,2,3,0,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h00,8'h00,0,5'h00,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,1,0, 8'h00,8'h00,0,5'b00001,0));
    tbl.push_back(mk(1,0,1,0,1,0,8'h00,5'b00110,2,3,0,0, 8'h00,8'h00,0,5'b00001,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,1, 8'h00,8'h00,0,5'b00001,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h00,8'h00,0,5'b00001,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,1,0, 8'h00,8'h00,0,5'b00001,0));
    tbl.push_back(mk(1,0,1,0,1,0,8'h00,5'b11111,2,3,0,0, 8'h00,8'h00,0,5'b00001,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,1,1, 8'h00,8'h00,0,5'b00001,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h00,8'h00,0,5'b11111,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,1, 8'h00,8'h00,0,5'b11111,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,1, 8'h00,8'h00,0,5'b00001,0));
    tbl.push_back(mk(1,0,0,0,0,0,8'h00,5'h00,2,3,0,0, 8'h00,8'h00,0,5'b00001,1));

    @(negedge clk);
    foreach (tbl[i]) step(tbl[i]);

    // randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      vec_t t;
      t.chk  = 1'b0;
      t.rst  = (i == 0) || ($urandom_range(0, 149) == 0);
      t.v    = ($urandom_range(0, 3) != 0);
      t.we   = 1'($urandom_range(0, 1));
      t.fe   = 1'($urandom_range(0, 1));
      t.dst  = 3'($urandom_range(0, 7));
      t.res  = 8'($urandom);
      t.fl   = 5'($urandom);
      t.ra   = 3'($urandom_range(0, 7));
      t.rb   = 3'($urandom_range(0, 7));
      t.push = ($urandom_range(0, 4) == 0);
      t.pop  = ($urandom_range(0, 4) == 0);
      t.ea = '0; t.eb = '0; t.eh = 1'b0; t.ef = '0; t.ee = 1'b0;
      step(t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
